// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute/writeback sequencer for the single-cycle RISC-V
// datapath. Owns the word-indexed PC, resolves branches, gates register-file
// and data-memory writes to one writeback cycle, supports free-run and
// single-step operation, halt detection and a retired-instruction counter.
module pc_sequencer #(
  parameter logic [9:0]  RESET_PC = 10'd0,
  parameter logic [9:0]  PC_LAST  = 10'd1023,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic [31:0]      instruction,
  input  logic             branch,
  input  logic             zero,
  input  logic [31:0]      immediate,
  input  logic             regwrite,
  input  logic             memwrite,
  output logic [9:0]       pc,
  output logic             reg_we,
  output logic             mem_we,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXECUTE,
    S_WRITEBACK,
    S_PAUSE,
    S_HALT
  } state_t;

  state_t           state, state_n;
  logic [9:0]       pc_n;
  logic             reg_we_n, mem_we_n;
  logic [CNT_W-1:0] cnt_n;
  logic             stop_insn;
  logic             take_branch;

  // Only the word-offset bits of the byte immediate feed the PC adder.
  logic unused_imm_bits;
  assign unused_imm_bits = ^{immediate[31:12], immediate[1:0]};

  // An all-zero word or any SYSTEM-opcode instruction stops the sequencer.
  always_comb begin
    stop_insn   = (instruction == 32'h0) || (instruction[6:0] == 7'b1110011);
    take_branch = branch & zero;
  end

  // Next-state, next-PC, write-strobe and counter logic.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    reg_we_n = 1'b0;
    mem_we_n = 1'b0;
    cnt_n    = retired_count;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_n    = RESET_PC;
          cnt_n   = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_EXECUTE;
      S_EXECUTE: begin
        if (stop_insn) begin
          state_n = S_HALT;
        end else begin
          state_n  = S_WRITEBACK;
          reg_we_n = regwrite;
          mem_we_n = memwrite;
        end
      end
      S_WRITEBACK: begin
        if (retired_count != '1) cnt_n = retired_count + CNT_W'(1);
        state_n = step_mode ? S_PAUSE : S_FETCH;
        if (take_branch) begin
          pc_n = pc + immediate[11:2];
        end else if (pc == PC_LAST) begin
          state_n = S_HALT;
        end else begin
          pc_n = pc + 10'd1;
        end
      end
      S_PAUSE: begin
        if (step || !step_mode) state_n = S_FETCH;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, PC, strobe and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      reg_we        <= 1'b0;
      mem_we        <= 1'b0;
      retired_count <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      reg_we        <= reg_we_n;
      mem_we        <= mem_we_n;
      retired_count <= cnt_n;
    end
  end

  // Status flags decoded directly from the state register.
  always_comb begin
    busy   = (state == S_FETCH) || (state == S_EXECUTE) ||
             (state == S_WRITEBACK) || (state == S_PAUSE);
    halted = (state == S_HALT);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: program-table driven bench for pc_sequencer with a
// retirement scoreboard on the default instance and direct checks on a
// small instance (PC_LAST=3, 3-bit counter) for boundary behaviour.
module tb_pc_sequencer;

  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] SW    = 32'h0020a023;
  localparam logic [31:0] BEQ   = 32'h00000063;
  localparam logic [31:0] ECALL = 32'h00000073;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, step_mode, step, start_b;
  logic [31:0] instruction, immediate, instruction_b, immediate_b;
  logic        branch, zero, regwrite, memwrite;
  logic        branch_b, zero_b, regwrite_b, memwrite_b;
  logic [9:0]  pc, pc_b;
  logic        reg_we, mem_we, busy, halted;
  logic        reg_we_b, mem_we_b, busy_b, halted_b;
  logic [15:0] retired_count;
  logic [2:0]  retired_count_b;

  logic [31:0] p_instr [1024];
  logic [31:0] p_imm   [1024];
  logic        p_br    [1024];
  logic        p_z     [1024];
  logic        p_rw    [1024];
  logic        p_mw    [1024];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  pc;
    logic [1:0]  we;
    logic [9:0]  npc;
    logic [15:0] cnt;
  } exp_t;
  exp_t sbq[$];

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
    .instruction(instruction), .branch(branch), .zero(zero), .immediate(immediate),
    .regwrite(regwrite), .memwrite(memwrite), .pc(pc), .reg_we(reg_we),
    .mem_we(mem_we), .busy(busy), .halted(halted), .retired_count(retired_count)
  );

  pc_sequencer #(.RESET_PC(10'd0), .PC_LAST(10'd3), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .step_mode(1'b0), .step(1'b0),
    .instruction(instruction_b), .branch(branch_b), .zero(zero_b),
    .immediate(immediate_b), .regwrite(regwrite_b), .memwrite(memwrite_b),
    .pc(pc_b), .reg_we(reg_we_b), .mem_we(mem_we_b), .busy(busy_b),
    .halted(halted_b), .retired_count(retired_count_b)
  );

  // Instruction memory and decoded control, looked up by each PC.
  always_comb begin
    instruction   = p_instr[pc];
    immediate     = p_imm[pc];
    branch        = p_br[pc];
    zero          = p_z[pc];
    regwrite      = p_rw[pc];
    memwrite      = p_mw[pc];
    instruction_b = p_instr[pc_b];
    immediate_b   = p_imm[pc_b];
    branch_b      = p_br[pc_b];
    zero_b        = p_z[pc_b];
    regwrite_b    = p_rw[pc_b];
    memwrite_b    = p_mw[pc_b];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) begin
      p_instr[i] = 32'h0; p_imm[i] = 32'h0;
      p_br[i] = 1'b0; p_z[i] = 1'b0; p_rw[i] = 1'b0; p_mw[i] = 1'b0;
    end
  endtask

  task automatic put(input int a, input logic [31:0] ins, input logic br, input logic z,
                     input logic rw, input logic mw, input logic [31:0] imm);
    p_instr[a] = ins; p_br[a] = br; p_z[a] = z; p_rw[a] = rw; p_mw[a] = mw; p_imm[a] = imm;
  endtask

  // Reference walk of the loaded program for the default instance: pushes one
  // entry per retirement, returns final pc/count and start-to-halt cycles.
  task automatic predict(output logic [9:0] fpc, output logic [15:0] fcnt, output int fcyc);
    logic [9:0]  p = 10'd0;
    logic [9:0]  np;
    logic [31:0] tgt;
    logic [31:0] ins;
    logic        stop = 1'b0;
    exp_t        e;
    fcnt = 16'd0;
    fcyc = 1;
    for (int k = 0; k < 200 && !stop; k++) begin
      ins = p_instr[p];
      if (ins == 32'h0 || ins[6:0] == 7'h73) begin
        fcyc += 2;
        stop = 1'b1;
      end else begin
        fcnt++;
        if (p_br[p] && p_z[p]) begin
          tgt = {20'b0, p, 2'b00} + p_imm[p];
          np  = tgt[11:2];
        end else if (p == 10'd1023) begin
          np   = p;
          stop = 1'b1;
        end else begin
          np = p + 10'd1;
        end
        e.pc = p; e.we = {p_rw[p], p_mw[p]}; e.npc = np; e.cnt = fcnt;
        sbq.push_back(e);
        fcyc += 3;
        p = np;
      end
    end
    fpc = p;
  endtask

  // Retirement monitor: a count increment pops one expected entry; strobes
  // seen in a cycle that does not retire are flagged.
  task automatic monitor();
    logic [9:0]  pv_pc = 10'd0;
    logic [1:0]  pv_we = 2'b00;
    logic [15:0] pv_cnt = 16'd0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv_pc = pc; pv_we = 2'b00; pv_cnt = 16'd0;
      end else begin
        if (retired_count == pv_cnt + 16'd1) begin
          if (sbq.size() == 0) begin
            chk("sb_unexpected_retire", retired_count, pv_cnt);
          end else begin
            e = sbq.pop_front();
            chk("sb_pc", pv_pc, e.pc);
            chk("sb_we", pv_we, e.we);
            chk("sb_npc", pc, e.npc);
            chk("sb_cnt", retired_count, e.cnt);
          end
        end else if (pv_we != 2'b00) begin
          chk("strobe_no_retire", pv_we, 2'b00);
        end
        pv_pc = pc; pv_we = {reg_we, mem_we}; pv_cnt = retired_count;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_prog(input int glitch_at);
    logic [9:0]  fpc;
    logic [15:0] fcnt;
    int          fcyc;
    int          cyc;
    predict(fpc, fcnt, fcyc);
    pulse_start();
    cyc = 1;
    chk("restart_pc", pc, 10'd0);
    chk("restart_cnt", retired_count, 16'd0);
    chk("restart_halted", halted, 1'b0);
    while (!halted && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == glitch_at);
    end
    start = 1'b0;
    chk("halted", halted, 1'b1);
    chk("busy_at_halt", busy, 1'b0);
    chk("pc_end", pc, fpc);
    chk("cnt_end", retired_count, fcnt);
    chk("cycles", cyc, fcyc);
    @(negedge clk); #1;
    chk("sb_empty", sbq.size(), 0);
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int limit);
    int n = 0;
    while (retired_count != target && n < limit) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_cnt", retired_count, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  fpc;
    logic [15:0] fcnt;
    int          fcyc;
    int          n;
    logic        stable;

    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; start_b = 1'b0;
    clear_prog();
    fork monitor(); join_none
    #12 rst_n = 1'b1;
    #1;
    chk("rst_pc", pc, 10'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_we", {reg_we, mem_we}, 2'b00);
    chk("rst_cnt", retired_count, 16'd0);

    // Free run: 4 addi then word 0; a start pulse mid-run must be ignored.
    for (int i = 0; i < 4; i++) put(i, ADDI, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    run_prog(5);

    // Store gating plus a branch with zero=1 but branch=0 (not taken).
    clear_prog();
    put(0, ADDI, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    put(1, ADDI, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
    put(2, SW,   1'b0, 1'b0, 1'b0, 1'b1, 32'h8);
    run_prog(0);

    // Backward taken branch: 0 -> 5, 5 -(-8)-> 3, ecall at 3.
    clear_prog();
    put(0, BEQ,   1'b1, 1'b1, 1'b0, 1'b0, 32'd20);
    put(5, BEQ,   1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8);
    put(3, ECALL, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    run_prog(0);

    // Same branch not taken (zero=0) -> 6.
    p_z[5] = 1'b0;
    run_prog(0);

    // Forward taken branch +12 from 5 -> 8.
    p_z[5] = 1'b1; p_imm[5] = 32'd12;
    run_prog(0);

    // Branch wraps 0 -> 1023; straight-line at PC_LAST halts in place.
    clear_prog();
    put(0,    BEQ,  1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    put(1023, ADDI, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    run_prog(0);

    // Step mode.
    clear_prog();
    for (int i = 0; i < 4; i++) put(i, ADDI, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    predict(fpc, fcnt, fcyc);
    step_mode = 1'b1;
    pulse_start();
    wait_cnt(16'd1, 20);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (pc != 10'd1 || reg_we || mem_we || !busy || retired_count != 16'd1) stable = 1'b0;
    end
    chk("pause_hold", stable, 1'b1);
    chk("pause_pc", pc, 10'd1);
    step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    wait_cnt(16'd2, 20);
    repeat (5) @(posedge clk);
    #1;
    chk("pause2_pc", pc, 10'd2);
    chk("pause2_cnt", retired_count, 16'd2);
    step_mode = 1'b0;
    n = 0;
    while (!halted && n < 100) begin @(posedge clk); #1; n++; end
    chk("step_halted", halted, 1'b1);
    chk("step_pc_end", pc, fpc);
    chk("step_cnt_end", retired_count, fcnt);
    @(negedge clk); #1;
    chk("step_sb_empty", sbq.size(), 0);

    // Reset in the middle of a writeback strobe.
    predict(fpc, fcnt, fcyc);
    pulse_start();
    n = 0;
    while (!reg_we && n < 20) begin @(posedge clk); #1; n++; end
    chk("wb_reached", reg_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_reg_we", reg_we, 1'b0);
    chk("midrst_pc", pc, 10'd0);
    chk("midrst_cnt", retired_count, 16'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_halted", halted, 1'b0);
    sbq.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_hold_busy", busy, 1'b0);
    chk("idle_hold_pc", pc, 10'd0);

    // Small instance: straight-line to PC_LAST=3.
    clear_prog();
    for (int i = 0; i < 6; i++) put(i, ADDI, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (!halted_b && n < 100) begin @(posedge clk); #1; n++; end
    chk("b_last_halted", halted_b, 1'b1);
    chk("b_last_pc", pc_b, 10'd3);
    chk("b_last_cnt", retired_count_b, 3'd4);

    // Small instance: ecall at pc=1, restarted from HALT.
    put(1, ECALL, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    chk("b_restart_pc", pc_b, 10'd0);
    chk("b_restart_cnt", retired_count_b, 3'd0);
    n = 0;
    while (!halted_b && n < 100) begin @(posedge clk); #1; n++; end
    chk("b_ecall_halted", halted_b, 1'b1);
    chk("b_ecall_pc", pc_b, 10'd1);
    chk("b_ecall_cnt", retired_count_b, 3'd1);

    // Small instance: self-branch loop saturates the 3-bit counter.
    put(0, BEQ, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("b_sat_cnt", retired_count_b, 3'd7);
    chk("b_sat_busy", busy_b, 1'b1);
    chk("b_sat_pc", pc_b, 10'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
